// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer
//   Shares one SPI_Host byte engine among NUM_REQ requesters. A round-robin
//   arbiter grants one requester at a time. For the granted requester it
//   asserts that requester's chip select and waits CS_SETUP clocks. It then
//   runs wlen write bytes followed by rlen read bytes through the host. After
//   the last byte it waits CS_HOLD clocks, releases the chip select and
//   pulses done.
//
//   Optional feature: define SPI_SEQ_TIMEOUT_EN to add a 16-bit per-byte
//   watchdog and the extra 'err' output. The default build has neither.
//
// Ports
//   clock, reset_n        system clock (rising edge), async active-low reset
//   req                   level request per requester, held until done
//   req_wlen / req_rlen   per-requester write / read byte counts (LEN_W each)
//   tx_data               per-requester current write byte (8 bits each)
//   tx_pop                one-hot pulse: granted requester's byte consumed
//   rx_data, rx_valid     last received byte, one-hot valid pulse
//   done                  one-hot pulse: transaction complete, cs_n released
//   err                   (SPI_SEQ_TIMEOUT_EN only) watchdog abort, with done
//   cs_n                  active-low chip selects, at most one low
//   host_data_ready       one-clock load strobe to SPI_Host
//   host_readmode         0 = write byte, 1 = read byte (valid with strobe)
//   host_data_input       byte to SPI_Host (valid with strobe)
//   host_busy             SPI_Host busy flag
//   host_data_output      SPI_Host received byte
module spi_txn_sequencer #(
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_wlen,
    input  logic [NUM_REQ*LEN_W-1:0] req_rlen,
    input  logic [NUM_REQ*8-1:0]     tx_data,
    output logic [NUM_REQ-1:0]       tx_pop,
    output logic [7:0]               rx_data,
    output logic [NUM_REQ-1:0]       rx_valid,
    output logic [NUM_REQ-1:0]       done,
`ifdef SPI_SEQ_TIMEOUT_EN
    output logic                     err,
`endif
    output logic [NUM_REQ-1:0]       cs_n,
    output logic                     host_data_ready,
    output logic                     host_readmode,
    output logic [7:0]               host_data_input,
    input  logic                     host_busy,
    input  logic [7:0]               host_data_output
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SETUP,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   sel_q;
    logic [LEN_W-1:0]   wlen_q, rlen_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               wr_phase;
    logic               byte_done;
    logic               more_bytes;
    logic               wd_expired;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Write bytes always precede read bytes, so a nonzero write count means
    // the byte in flight (or about to load) is a write.
    assign wr_phase   = (wlen_q != '0);
    assign byte_done  = (state_q == S_WAIT_DONE) && !host_busy;
    assign more_bytes = wr_phase ? ((wlen_q > LEN_W'(1)) || (rlen_q != '0))
                                 : (rlen_q > LEN_W'(1));

    // Round-robin pick: first set request at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        err_flag_q;
    assign wd_expired = ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE))
                        && (wd_q == 16'hFFFF);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (|req) state_d = S_GRANT;
            // The request may have been withdrawn between IDLE and GRANT.
            S_GRANT:     state_d = pick_found ? S_SETUP : S_IDLE;
            S_SETUP:     if (cnt_q == CNT_W'(CS_SETUP - 1))
                             state_d = ((wlen_q == '0) && (rlen_q == '0)) ? S_HOLD : S_LOAD;
            S_LOAD:      state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (host_busy)       state_d = S_WAIT_DONE;
                         else if (wd_expired) state_d = S_HOLD;
            S_WAIT_DONE: if (!host_busy)      state_d = more_bytes ? S_LOAD : S_HOLD;
                         else if (wd_expired) state_d = S_HOLD;
            S_HOLD:      if (cnt_q == CNT_W'(CS_HOLD - 1)) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Host strobe and write-byte handshake are decoded from state so they
    // vanish the instant reset asserts.
    always_comb begin
        host_data_ready = 1'b0;
        host_readmode   = 1'b0;
        host_data_input = '0;
        tx_pop          = '0;
        if (state_q == S_LOAD) begin
            host_data_ready = 1'b1;
            if (wr_phase) begin
                host_data_input = tx_data[int'(sel_q)*8 +: 8];
                tx_pop          = onehot(sel_q);
            end else begin
                host_readmode   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            wlen_q   <= '0;
            rlen_q   <= '0;
            cnt_q    <= '0;
            cs_n     <= '1;
            done     <= '0;
            rx_valid <= '0;
            rx_data  <= '0;
        end else begin
            done     <= '0;
            rx_valid <= '0;
            cnt_q    <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

            if ((state_q == S_GRANT) && pick_found) begin
                sel_q    <= pick_idx;
                wlen_q   <= req_wlen[int'(pick_idx)*LEN_W +: LEN_W];
                rlen_q   <= req_rlen[int'(pick_idx)*LEN_W +: LEN_W];
                cs_n     <= ~onehot(pick_idx);
                rr_ptr_q <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end

            if (byte_done) begin
                if (wr_phase) begin
                    wlen_q <= wlen_q - LEN_W'(1);
                end else begin
                    rlen_q   <= rlen_q - LEN_W'(1);
                    rx_data  <= host_data_output;
                    rx_valid <= onehot(sel_q);
                end
            end

            if ((state_q == S_HOLD) && (state_d == S_IDLE)) begin
                cs_n <= '1;
                done <= onehot(sel_q);
            end
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog restarts with each byte; an expiry skips the remaining bytes
    // and is reported with the done pulse of the same transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q       <= '0;
            err_flag_q <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            if ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) wd_q <= wd_q + 16'd1;
            else                                                      wd_q <= '0;
            if (state_q == S_GRANT) err_flag_q <= 1'b0;
            else if (wd_expired)    err_flag_q <= 1'b1;
            if ((state_q == S_HOLD) && (state_d == S_IDLE)) err <= err_flag_q;
        end
    end
`endif

endmodule
